// File: rtl/keypad_pkg.sv
// Shared encodings for matrix-keypad consumers: symbol codes, entry FSM states
// and the raw scanner index to symbol keymap.
package keypad_pkg;

    localparam logic [3:0] SYM_A    = 4'd10;
    localparam logic [3:0] SYM_B    = 4'd11;
    localparam logic [3:0] SYM_C    = 4'd12;
    localparam logic [3:0] SYM_D    = 4'd13;
    localparam logic [3:0] SYM_STAR = 4'd14;
    localparam logic [3:0] SYM_HASH = 4'd15;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } entry_state_e;

    // Indexed by row*4 + col of the physical 4x4 matrix.
    localparam logic [3:0] KEYMAP [16] = '{
        4'd1,     4'd2, 4'd3,     SYM_A,
        4'd4,     4'd5, 4'd6,     SYM_B,
        4'd7,     4'd8, 4'd9,     SYM_C,
        SYM_STAR, 4'd0, SYM_HASH, SYM_D
    };

endpackage

// File: rtl/keypad_keymap.sv
// Combinational raw key index to symbol translation, shared by all keypad
// consumers.
module keypad_keymap
    import keypad_pkg::*;
(
    input  logic [3:0] key_code,
    output logic [3:0] symbol,
    output logic       is_digit
);

    always_comb begin
        symbol   = KEYMAP[key_code];
        is_digit = (symbol < 4'd10);
    end

endmodule

// File: rtl/keypad_entry.sv
// Assembles keypad digits into a right-aligned BCD entry with enter, backspace,
// clear and an inactivity timeout that discards stale partial entries.
//
//   state      | meaning
//   -----------+-------------------------------------------
//   ST_EMPTY   | no digits held, idle counter parked at 0
//   ST_PARTIAL | 0 < entry_len < DIGITS, idle counter runs
//   ST_FULL    | entry_len == DIGITS, further digits overflow
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [3:0]                  key_code,
    input  logic                        data_ready,
    output logic [4*DIGITS-1:0]         entry_bcd,
    output logic [$clog2(DIGITS+1)-1:0] entry_len,
    output logic [4*DIGITS-1:0]         value_bcd,
    output logic                        value_valid,
    output logic                        overflow,
    output logic                        timeout
);

    localparam int LW = $clog2(DIGITS + 1);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    entry_state_e           state, state_n;
    logic [CW-1:0]          idle_cnt, cnt_n;
    logic [4*DIGITS-1:0]    entry_n, value_n, shifted;
    logic [LW-1:0]          len_n;
    logic                   vv_n, ov_n, to_n;
    logic [3:0]             sym;
    logic                   is_digit;

    keypad_keymap u_keymap (
        .key_code (key_code),
        .symbol   (sym),
        .is_digit (is_digit)
    );

    always_comb begin
        shifted      = entry_bcd << 4;
        shifted[3:0] = sym;
    end

    always_comb begin
        entry_n = entry_bcd;
        len_n   = entry_len;
        value_n = value_bcd;
        vv_n    = 1'b0;
        ov_n    = 1'b0;
        to_n    = 1'b0;
        cnt_n   = '0;

        if (data_ready) begin
            // Any key, including ignored ones, restarts the idle counter.
            if (is_digit) begin
                if (state != ST_FULL) begin
                    entry_n = shifted;
                    len_n   = entry_len + LW'(1);
                end else begin
                    ov_n = 1'b1;
                end
            end else begin
                case (sym)
                    SYM_HASH: if (state != ST_EMPTY) begin
                        value_n = entry_bcd;
                        vv_n    = 1'b1;
                        entry_n = '0;
                        len_n   = '0;
                    end
                    SYM_STAR: if (state != ST_EMPTY) begin
                        entry_n = entry_bcd >> 4;
                        len_n   = entry_len - LW'(1);
                    end
                    SYM_D: begin
                        entry_n = '0;
                        len_n   = '0;
                    end
                    default: ;
                endcase
            end
        end else if (state != ST_EMPTY && TIMEOUT_CYCLES != 0) begin
            if (idle_cnt == CNT_LAST) begin
                entry_n = '0;
                len_n   = '0;
                to_n    = 1'b1;
            end else begin
                cnt_n = idle_cnt + CW'(1);
            end
        end

        if (len_n == '0)
            state_n = ST_EMPTY;
        else if (len_n == LW'(DIGITS))
            state_n = ST_FULL;
        else
            state_n = ST_PARTIAL;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_EMPTY;
            idle_cnt    <= '0;
            entry_bcd   <= '0;
            entry_len   <= '0;
            value_bcd   <= '0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            idle_cnt    <= cnt_n;
            entry_bcd   <= entry_n;
            entry_len   <= len_n;
            value_bcd   <= value_n;
            value_valid <= vv_n;
            overflow    <= ov_n;
            timeout     <= to_n;
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with DIGITS=4 and a short 20-cycle timeout.
module tb_keypad_entry;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  key_code;
    logic        data_ready;
    logic [15:0] entry_bcd;
    logic [2:0]  entry_len;
    logic [15:0] value_bcd;
    logic        value_valid;
    logic        overflow;
    logic        timeout;

    int n_checks = 0;
    int n_pass   = 0;

    keypad_entry #(
        .DIGITS         (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_code    (key_code),
        .data_ready  (data_ready),
        .entry_bcd   (entry_bcd),
        .entry_len   (entry_len),
        .value_bcd   (value_bcd),
        .value_valid (value_valid),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic key(input logic [3:0] raw);
        key_code   = raw;
        data_ready = 1'b1;
        @(posedge clock); #1;
        data_ready = 1'b0;
        key_code   = 4'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
        end
    endtask

    function automatic logic [31:0] pulses();
        return {29'd0, value_valid, overflow, timeout};
    endfunction

    logic saw_to;

    initial begin
        reset = 1'b1; data_ready = 1'b0; key_code = 4'd0;
        idle(2);
        reset = 1'b0;
        check("reset_entry", entry_bcd, 0);
        check("reset_len",   entry_len, 0);
        check("reset_value", value_bcd, 0);
        check("reset_pulse", pulses(), 0);

        // 1,2,3 then enter
        key(4'd0); key(4'd1); key(4'd2);
        check("t1_entry", entry_bcd, 16'h0123);
        check("t1_len",   entry_len, 3);
        key(4'd14);
        check("t1_pulse", pulses(), 3'b100);
        check("t1_value", value_bcd, 16'h0123);
        check("t1_len0",  entry_len, 0);
        check("t1_ent0",  entry_bcd, 0);
        idle(1);
        check("t1_pulse_end", pulses(), 0);

        // fill 0,1,2,3 then overflow with 4
        key(4'd13); key(4'd0); key(4'd1); key(4'd2);
        check("t2_len_full", entry_len, 4);
        key(4'd4);
        check("t2_entry", entry_bcd, 16'h0123);
        check("t2_len",   entry_len, 4);
        check("t2_pulse", pulses(), 3'b010);
        idle(1);
        check("t2_pulse_end", pulses(), 0);
        key(4'd15);
        check("t2_clear", entry_bcd, 0);

        // 5,6 backspace, then clear
        key(4'd5); key(4'd6);
        check("t3_entry56", entry_bcd, 16'h0056);
        key(4'd12);
        check("t3_bs_entry", entry_bcd, 16'h0005);
        check("t3_bs_len",   entry_len, 1);
        key(4'd15);
        check("t3_clr_entry", entry_bcd, 0);
        check("t3_clr_len",   entry_len, 0);
        check("t3_value",     value_bcd, 16'h0123);

        // digit 7 then 20 idle cycles: expiry on the 20th
        key(4'd8);
        saw_to = 1'b0;
        for (int i = 0; i < 19; i++) begin
            idle(1);
            if (timeout) saw_to = 1'b1;
        end
        check("t4_early_to", {31'd0, saw_to}, 0);
        check("t4_held", entry_bcd, 16'h0007);
        idle(1);
        check("t4_pulse", pulses(), 3'b001);
        check("t4_entry", entry_bcd, 0);
        check("t4_len",   entry_len, 0);
        idle(1);
        check("t4_pulse_end", pulses(), 0);

        // repeat with digit 8 arriving on the would-be expiry cycle
        key(4'd8);
        idle(19);
        key(4'd9);
        check("t4b_pulse", pulses(), 0);
        check("t4b_entry", entry_bcd, 16'h0078);
        check("t4b_len",   entry_len, 2);
        idle(19);
        check("t4b_restart", entry_bcd, 16'h0078);
        idle(1);
        check("t4b_to", pulses(), 3'b001);

        // enter while empty, A mid-entry
        key(4'd14);
        check("t5_empty_enter", pulses(), 0);
        check("t5_value", value_bcd, 16'h0123);
        key(4'd0);
        key(4'd3);
        check("t5_a_pulse", pulses(), 0);
        check("t5_a_entry", entry_bcd, 16'h0001);
        check("t5_a_len",   entry_len, 1);

        // reset mid-entry wins over a simultaneous key
        key(4'd1);
        reset = 1'b1; key_code = 4'd14; data_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; data_ready = 1'b0;
        check("t6_entry", entry_bcd, 0);
        check("t6_len",   entry_len, 0);
        check("t6_value", value_bcd, 0);
        check("t6_pulse", pulses(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
